// File: rtl/heartbeat_generator.sv
// Heartbeat generator: classifies emotion/state into a 2-bit level and emits a timed beat train.
// Optional HEARTBEAT_SLEW_EN makes the beat period slew toward the target instead of jumping to it.
module heartbeat_generator #(
  parameter int               EMO_W         = 8,
  parameter logic [EMO_W-1:0] SLOW_MASK     = 8'h18,
  parameter logic [EMO_W-1:0] CALM_MASK     = 8'h03,
  parameter int               CNT_W         = 8,
  parameter int               PERIOD_FAST   = 8,
  parameter int               PERIOD_NORMAL = 16,
  parameter int               PERIOD_SLOW   = 32,
  parameter int               PERIOD_REST   = 48,
  parameter int               PULSE_TICKS   = 2,
  parameter int               SLEW_STEP     = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic [EMO_W-1:0] emotion,
  input  logic [1:0]       state,
  output logic [1:0]       level,
  output logic             beat,
  output logic             led,
  output logic [CNT_W-1:0] period
);

  localparam logic [CNT_W-1:0] P_FAST   = CNT_W'(PERIOD_FAST);
  localparam logic [CNT_W-1:0] P_NORMAL = CNT_W'(PERIOD_NORMAL);
  localparam logic [CNT_W-1:0] P_SLOW   = CNT_W'(PERIOD_SLOW);
  localparam logic [CNT_W-1:0] P_REST   = CNT_W'(PERIOD_REST);
  localparam logic [CNT_W-1:0] P_PULSE  = CNT_W'(PULSE_TICKS);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] stretch;
  logic [CNT_W-1:0] target;
  logic [CNT_W-1:0] next_period;
  logic             dead;
  logic             wrap;

  // Dead is taken straight from the input so it beats a same-cycle wrapping tick.
  assign dead = (state == 2'd3);
  assign wrap = tick && !dead && (cnt == period - CNT_W'(1));
  assign led  = (stretch != '0);

  always_comb begin
    target = P_NORMAL;
    case (level)
      2'd0: target = P_FAST;
      2'd1: target = P_NORMAL;
      2'd2: target = P_SLOW;
      2'd3: target = P_REST;
      default: target = P_NORMAL;
    endcase
  end

`ifdef HEARTBEAT_SLEW_EN
  logic [CNT_W-1:0] diff;
  logic [CNT_W-1:0] step;

  always_comb begin
    diff = (target >= period) ? (target - period) : (period - target);
    step = (diff > CNT_W'(SLEW_STEP)) ? CNT_W'(SLEW_STEP) : diff;
    next_period = (target >= period) ? (period + step) : (period - step);
  end
`else
  always_comb begin
    next_period = target;
  end
`endif

  // NOTE: sequential state uses non-blocking assignments only; the reset branch is
  // synchronous and covers every register, so no flop powers up undefined.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      level   <= 2'd0;
      beat    <= 1'b0;
      period  <= P_NORMAL;
      cnt     <= '0;
      stretch <= '0;
    end else begin
      level <= {(|state) | (|(emotion & SLOW_MASK)),
                (|state) | (|(emotion & CALM_MASK))};
      beat  <= wrap;
      if (dead) begin
        cnt     <= '0;
        stretch <= '0;
      end else if (tick) begin
        if (wrap) begin
          cnt     <= '0;
          stretch <= P_PULSE;
          period  <= next_period;
        end else begin
          cnt <= cnt + CNT_W'(1);
          if (stretch != '0) stretch <= stretch - CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_heartbeat_generator.sv
// Directed self-checking bench for heartbeat_generator (default parameters).
// Expectations follow HEARTBEAT_SLEW_EN when it is defined for the build.
module tb_heartbeat_generator;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tick;
  logic [7:0] emotion;
  logic [1:0] state;
  logic [1:0] level;
  logic       beat;
  logic       led;
  logic [7:0] period;

  int checks = 0;
  int errors = 0;
  int since  = 0;

`ifdef HEARTBEAT_SLEW_EN
  localparam int NB = 6;
  localparam int SP_EXP  [NB] = '{16, 14, 12, 10, 8, 8};
  localparam int PER_EXP [NB] = '{14, 12, 10, 8, 8, 8};
  localparam int RUN_TO_12 = 2;
  localparam int RST_P     = 12;
  localparam int POST_RST_P = 14;
`else
  localparam int NB = 3;
  localparam int SP_EXP  [NB] = '{16, 8, 8};
  localparam int PER_EXP [NB] = '{8, 8, 8};
  localparam int RUN_TO_12 = 1;
  localparam int RST_P     = 8;
  localparam int POST_RST_P = 8;
`endif

  heartbeat_generator dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .tick    (tick),
    .emotion (emotion),
    .state   (state),
    .level   (level),
    .beat    (beat),
    .led     (led),
    .period  (period)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    since++;
  endtask

  // Steps until beat is seen (bounded); div>1 drives tick on every div-th clk.
  task automatic wait_beat(input int limit, input int div, output int n);
    do begin
      if (div > 1) tick = (((since + 1) % div) == 0);
      step();
    end while (!beat && since < limit);
    n     = since;
    since = 0;
  endtask

  initial begin
    int n;
    int beats;
    int leds;

    rst_n = 1'b0; tick = 1'b0; emotion = 8'h00; state = 2'd0;
    repeat (2) step();
    check("rst_level",  level,  0);
    check("rst_beat",   beat,   0);
    check("rst_led",    led,    0);
    check("rst_period", period, 16);

    // Normal operation, tick tied high, level 1.
    rst_n = 1'b1; tick = 1'b1; emotion = 8'h01; since = 0;
    step();
    check("level_latency", level, 1);
    wait_beat(100, 1, n);
    check("first_beat_spacing", n, 16);
    check("beat_high", beat, 1);
    check("led_on_beat", led, 1);
    step();
    check("beat_one_clk", beat, 0);
    check("led_second_clk", led, 1);
    step();
    check("led_off", led, 0);
    wait_beat(100, 1, n);
    check("steady_spacing", n, 16);
    check("steady_period", period, 16);

    // Classifier with tick held low: counters hold, level tracks.
    tick = 1'b0;
    emotion = 8'h09; step(); check("cls_09", level, 3);
    emotion = 8'h10; step(); check("cls_10", level, 2);
    emotion = 8'h20; step(); check("cls_20", level, 0);
    emotion = 8'h00; state = 2'd1; step(); check("cls_sleep", level, 3);
    state = 2'd0; emotion = 8'h10;
    beats = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (beat) beats++;
    end
    check("tick_low_beats", beats, 0);
    check("tick_low_level", level, 2);
    check("tick_low_period", period, 16);
    emotion = 8'h01; step();
    check("cls_01", level, 1);

    // Rate change mid-interval: 8'h01 -> 8'h20 after 5 ticks.
    since = 0; tick = 1'b1;
    repeat (5) step();
    emotion = 8'h20;
    for (int b = 0; b < NB; b++) begin
      wait_beat(100, 1, n);
      check($sformatf("slew_spacing_%0d", b), n, SP_EXP[b]);
      check($sformatf("slew_period_%0d", b), period, PER_EXP[b]);
    end

    // Back to level 1 and run until the period has returned to 16.
    emotion = 8'h01;
    for (int b = 0; b < 8; b++) begin
      if (period != 8'd16) wait_beat(100, 1, n);
    end
    check("back_to_16", period, 16);

    // Tick every 4th clk at period 16: beats 64 clks apart.
    wait_beat(200, 4, n);
    check("div4_spacing_a", n, 64);
    wait_beat(200, 4, n);
    check("div4_spacing_b", n, 64);

    // Enter dead on the clk that would wrap, then stay dead for 100 clks.
    tick = 1'b1;
    repeat (15) step();
    state = 2'd3;
    step();
    check("dead_on_wrap_beat", beat, 0);
    beats = 0; leds = 0;
    for (int i = 0; i < 99; i++) begin
      step();
      if (beat) beats++;
      if (led) leds++;
    end
    check("dead_beats", beats, 0);
    check("dead_leds", leds, 0);
    check("dead_period", period, 16);
    check("dead_level", level, 3);
    state = 2'd0; since = 0;
    wait_beat(100, 1, n);
    check("leave_dead_spacing", n, 16);

    // Reset on the clk that would wrap: beat suppressed, interval restarts at 16.
    emotion = 8'h20;
    for (int b = 0; b < RUN_TO_12; b++) wait_beat(100, 1, n);
    check("pre_rst_period", period, RST_P);
    repeat (RST_P - 1) step();
    rst_n = 1'b0;
    step();
    check("midrst_level",  level,  0);
    check("midrst_beat",   beat,   0);
    check("midrst_led",    led,    0);
    check("midrst_period", period, 16);
    rst_n = 1'b1; since = 0;
    wait_beat(100, 1, n);
    check("post_rst_spacing", n, 16);
    check("post_rst_period", period, POST_RST_P);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
